// File: rtl/gate_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gate_unit_arbiter
// Purpose  : Round-robin front-end sharing one two-operand bitwise logic
//            unit (AND/OR/XOR/NAND) among four requesters.
// Revision : 1.0 - initial release
// ============================================================================
module gate_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [7:0]           op_flat,
    input  logic [4*WIDTH-1:0]   a_flat,
    input  logic [4*WIDTH-1:0]   b_flat,
    output logic [3:0]           gnt,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [1:0]           result_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] c_OP_AND = 2'b00;
    localparam logic [1:0] c_OP_OR  = 2'b01;
    localparam logic [1:0] c_OP_XOR = 2'b10;

    state_t             r_state;
    logic [1:0]         r_rr_ptr;
    logic [1:0]         r_id;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;

    logic               w_found;
    logic [1:0]         w_pick;
    logic [1:0]         w_idx;
    logic [WIDTH-1:0]   w_result;

    // Scan starting at the round-robin pointer; first pending requester wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        w_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        case (r_op)
            c_OP_AND: w_result = r_a & r_b;
            c_OP_OR:  w_result = r_a | r_b;
            c_OP_XOR: w_result = r_a ^ r_b;
            default:  w_result = ~(r_a & r_b);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= 2'd0;
            r_id      <= 2'd0;
            r_op      <= 2'd0;
            r_a       <= '0;
            r_b       <= '0;
            gnt       <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_id <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id    <= w_pick;
                        r_op    <= op_flat[2*w_pick +: 2];
                        r_a     <= a_flat[WIDTH*w_pick +: WIDTH];
                        r_b     <= b_flat[WIDTH*w_pick +: WIDTH];
                        gnt     <= 4'(4'b0001 << w_pick);
                        busy    <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result    <= w_result;
                    result_id <= r_id;
                    done      <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    // Served requester drops to lowest priority next round.
                    r_rr_ptr <= r_id + 2'd1;
                    gnt      <= 4'd0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    gnt     <= 4'd0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_unit_arbiter
// Purpose  : Self-checking bench for gate_unit_arbiter with a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_unit_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     req;
    logic [7:0]     op_flat;
    logic [4*W-1:0] a_flat;
    logic [4*W-1:0] b_flat;
    logic [3:0]     gnt;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic [1:0]     result_id;

    int n_cmp = 0;
    int n_bad = 0;
    int tb_rr = 0;

    gate_unit_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_flat   (op_flat),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_id (result_id)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < 4; k++)
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [W-1:0] gate(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req = 4'(1 << i);
        op_flat[2*i +: 2] = op;
        a_flat[W*i +: W]  = a;
        b_flat[W*i +: W]  = b;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 4'd0; op_flat = '0; a_flat = '0; b_flat = '0;
        repeat (3) @(negedge clk);
        n_cmp += 5;
        if (gnt !== 4'd0)       begin n_bad++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        if (result !== '0)      begin n_bad++; $display("FAIL reset_result: got %h expected 00", result); end
        if (result_id !== 2'd0) begin n_bad++; $display("FAIL reset_id: got %0d expected 0", result_id); end
        reset = 1'b0; tb_rr = 0;
    endtask

    task automatic test_basic;
        set_req(0, 2'b00, 8'hF0, 8'h3C);
        @(negedge clk);
        n_cmp += 3;
        if (gnt !== 4'b0001) begin n_bad++; $display("FAIL basic_gnt: got %b expected 0001", gnt); end
        if (busy !== 1'b1)   begin n_bad++; $display("FAIL basic_busy: got %b expected 1", busy); end
        if (done !== 1'b0)   begin n_bad++; $display("FAIL basic_early_done: got %b expected 0", done); end
        @(negedge clk);
        n_cmp += 4;
        if (done !== 1'b1)      begin n_bad++; $display("FAIL basic_done: got %b expected 1", done); end
        if (result !== 8'h30)   begin n_bad++; $display("FAIL basic_result: got %h expected 30", result); end
        if (result_id !== 2'd0) begin n_bad++; $display("FAIL basic_id: got %0d expected 0", result_id); end
        if (gnt !== 4'b0001)    begin n_bad++; $display("FAIL basic_resp_gnt: got %b expected 0001", gnt); end
        req = 4'd0; tb_rr = 1;
        @(negedge clk);
        n_cmp += 3;
        if (gnt !== 4'd0)  begin n_bad++; $display("FAIL basic_idle_gnt: got %b expected 0000", gnt); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL basic_idle_done: got %b expected 0", done); end
    endtask

    task automatic test_ops;
        logic [W-1:0] exp_tbl [4];
        exp_tbl[0] = 8'h05; exp_tbl[1] = 8'hAF; exp_tbl[2] = 8'hAA; exp_tbl[3] = 8'hFA;
        for (int op = 0; op < 4; op++) begin
            set_req(2, 2'(op), 8'hA5, 8'h0F);
            repeat (2) @(negedge clk);
            n_cmp += 3;
            if (done !== 1'b1)           begin n_bad++; $display("FAIL op%0d_done: got %b expected 1", op, done); end
            if (result !== exp_tbl[op])  begin n_bad++; $display("FAIL op%0d_result: got %h expected %h", op, result, exp_tbl[op]); end
            if (result_id !== 2'd2)      begin n_bad++; $display("FAIL op%0d_id: got %0d expected 2", op, result_id); end
            req = 4'd0; tb_rr = 3;
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin;
        int last = -1;
        int got  = 0;
        int e;
        reset = 1'b1; req = 4'hF;
        op_flat = 8'($urandom); a_flat = $urandom; b_flat = $urandom;
        @(negedge clk);
        reset = 1'b0; tb_rr = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                e = pick(4'hF, tb_rr);
                n_cmp += 2;
                if (result_id !== 2'(e)) begin n_bad++; $display("FAIL rr_id%0d: got %0d expected %0d", got, result_id, e); end
                if (result !== gate(op_flat[2*e +: 2], a_flat[W*e +: W], b_flat[W*e +: W])) begin
                    n_bad++; $display("FAIL rr_result%0d: got %h expected %h", got, result,
                                      gate(op_flat[2*e +: 2], a_flat[W*e +: W], b_flat[W*e +: W]));
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != 3) begin n_bad++; $display("FAIL rr_spacing%0d: got %0d expected 3", got, cyc - last); end
                end
                last = cyc; tb_rr = (e + 1) % 4; got++;
            end
        end
        req = 4'd0;
        n_cmp++;
        if (got != 6) begin n_bad++; $display("FAIL rr_timeout: got %0d done pulses expected 6", got); end
        repeat (2) @(negedge clk);
        tb_rr = 2;
    endtask

    task automatic test_wrap;
        set_req(2, 2'b01, 8'h11, 8'h22);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (result_id !== 2'd2) begin n_bad++; $display("FAIL wrap_pre_id: got %0d expected 2", result_id); end
        req = 4'd0;
        @(negedge clk);
        req = 4'b0101;
        op_flat[1:0] = 2'b10; a_flat[W-1:0]   = 8'h5A; b_flat[W-1:0]   = 8'hFF;
        op_flat[5:4] = 2'b00; a_flat[2*W +: W] = 8'h3C; b_flat[2*W +: W] = 8'h0F;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_gnt0: got %b expected 0001", gnt); end
        @(negedge clk);
        n_cmp += 2;
        if (result_id !== 2'd0) begin n_bad++; $display("FAIL wrap_id0: got %0d expected 0", result_id); end
        if (result !== 8'hA5)   begin n_bad++; $display("FAIL wrap_res0: got %h expected a5", result); end
        req = 4'b0100;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0100) begin n_bad++; $display("FAIL wrap_gnt2: got %b expected 0100", gnt); end
        @(negedge clk);
        n_cmp += 3;
        if (done !== 1'b1)      begin n_bad++; $display("FAIL wrap_done2: got %b expected 1", done); end
        if (result_id !== 2'd2) begin n_bad++; $display("FAIL wrap_id2: got %0d expected 2", result_id); end
        if (result !== 8'h0C)   begin n_bad++; $display("FAIL wrap_res2: got %h expected 0c", result); end
        req = 4'd0; tb_rr = 3;
        @(negedge clk);
    endtask

    task automatic test_latch;
        set_req(1, 2'b01, 8'hFF, 8'h00);
        @(negedge clk);
        a_flat[W +: W] = 8'h00; req[1] = 1'b0; op_flat[3:2] = 2'b00;
        @(negedge clk);
        n_cmp += 3;
        if (done !== 1'b1)      begin n_bad++; $display("FAIL latch_done: got %b expected 1", done); end
        if (result !== 8'hFF)   begin n_bad++; $display("FAIL latch_result: got %h expected ff", result); end
        if (result_id !== 2'd1) begin n_bad++; $display("FAIL latch_id: got %0d expected 1", result_id); end
        @(negedge clk);
        tb_rr = 2;
    endtask

    task automatic test_reset_mid;
        set_req(3, 2'b10, 8'h12, 8'h34);
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b1000) begin n_bad++; $display("FAIL rmid_gnt3: got %b expected 1000", gnt); end
        reset = 1'b1; req = 4'd0;
        @(negedge clk);
        n_cmp += 4;
        if (gnt !== 4'd0)  begin n_bad++; $display("FAIL rmid_gnt: got %b expected 0000", gnt); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b expected 0", done); end
        if (result !== '0) begin n_bad++; $display("FAIL rmid_result: got %h expected 00", result); end
        reset = 1'b0; tb_rr = 0;
        req = 4'b1001; op_flat[1:0] = 2'b11; a_flat[W-1:0] = 8'hF0; b_flat[W-1:0] = 8'hFF;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rmid_regrant: got %b expected 0001", gnt); end
        @(negedge clk);
        n_cmp += 2;
        if (result_id !== 2'd0) begin n_bad++; $display("FAIL rmid_id: got %0d expected 0", result_id); end
        if (result !== 8'h0F)   begin n_bad++; $display("FAIL rmid_res: got %h expected 0f", result); end
        req = 4'd0; tb_rr = 1;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [3:0] r;
        int e;
        logic [W-1:0] exp_res;
        for (int it = 0; it < 30; it++) begin
            r = 4'($urandom_range(1, 15));
            op_flat = 8'($urandom); a_flat = $urandom; b_flat = $urandom;
            req = r;
            e = pick(r, tb_rr);
            exp_res = gate(op_flat[2*e +: 2], a_flat[W*e +: W], b_flat[W*e +: W]);
            @(negedge clk);
            n_cmp += 2;
            if (gnt !== 4'(1 << e)) begin n_bad++; $display("FAIL rand%0d_gnt: got %b expected %b", it, gnt, 4'(1 << e)); end
            if (busy !== 1'b1)      begin n_bad++; $display("FAIL rand%0d_busy: got %b expected 1", it, busy); end
            op_flat = 8'($urandom); a_flat = $urandom; b_flat = $urandom; req = 4'($urandom);
            @(negedge clk);
            n_cmp += 3;
            if (done !== 1'b1)        begin n_bad++; $display("FAIL rand%0d_done: got %b expected 1", it, done); end
            if (result_id !== 2'(e))  begin n_bad++; $display("FAIL rand%0d_id: got %0d expected %0d", it, result_id, e); end
            if (result !== exp_res)   begin n_bad++; $display("FAIL rand%0d_result: got %h expected %h", it, result, exp_res); end
            req = 4'd0; tb_rr = (e + 1) % 4;
            @(negedge clk);
            n_cmp++;
            if (gnt !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
                n_bad++; $display("FAIL rand%0d_idle: got gnt=%b busy=%b done=%b expected 0000/0/0", it, gnt, busy, done);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_ops;
        test_round_robin;
        test_wrap;
        test_latch;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
